// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each access takes two cycles: ACCESS (grant + strobe), then DONE (completion + read data).

module dmem_arbiter_port #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          fin,
    input  logic          oor,
    input  logic [DW-1:0] cap,
    output logic          gnt,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt   <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            gnt  <= load;
            done <= fin;
            err  <= fin && oor;
            if (fin) rdata <= cap;
        end
    end
endmodule

module dmem_arbiter #(
    parameter int DEPTH = 21,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          a_done,
    output logic [DW-1:0] a_rdata,
    output logic          a_err,
    output logic          b_gnt,
    output logic          b_done,
    output logic [DW-1:0] b_rdata,
    output logic          b_err,
    output logic [AW-1:0] DMEM_address,
    output logic [DW-1:0] DMEM_data_in,
    output logic          DMEM_mem_write,
    output logic          DMEM_mem_read,
    input  logic [DW-1:0] DMEM_data_out
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    state_t          state, state_nxt;
    acc_t [1:0]      rq;
    acc_t            sel, acc_q;
    logic            go, pick, sel_oor;
    logic            win_q, oor_q, last_b;
    logic [DW-1:0]   cap;
    logic [1:0]      load, fin, gnt, done, err;
    logic [1:0][DW-1:0] rdata;

    assign rq[0] = '{we: a_we, addr: a_addr, wdata: a_wdata};
    assign rq[1] = '{we: b_we, addr: b_addr, wdata: b_wdata};

    // B wins only when A is absent or A was the one served last
    assign pick    = b_req && (!a_req || !last_b);
    assign sel     = rq[pick];
    assign sel_oor = sel.addr >= AW'(DEPTH);

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (a_req || b_req) begin
                    state_nxt = ACCESS;
                    go        = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            acc_q          <= '0;
            win_q          <= 1'b0;
            oor_q          <= 1'b0;
            last_b         <= 1'b1;
            DMEM_mem_write <= 1'b0;
            DMEM_mem_read  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (go) begin
                acc_q          <= sel;
                win_q          <= pick;
                oor_q          <= sel_oor;
                last_b         <= pick;
                DMEM_mem_write <= sel.we && !sel_oor;
                DMEM_mem_read  <= !sel.we && !sel_oor;
            end else begin
                DMEM_mem_write <= 1'b0;
                DMEM_mem_read  <= 1'b0;
            end
        end
    end

    assign DMEM_address = acc_q.addr;
    assign DMEM_data_in = acc_q.wdata;

    assign cap = (acc_q.we || oor_q) ? '0 : DMEM_data_out;

    for (genvar i = 0; i < 2; i++) begin : g_port
        assign load[i] = go && (pick == 1'(i));
        assign fin[i]  = (state == ACCESS) && (win_q == 1'(i));

        dmem_arbiter_port #(.DW(DW)) u_port (
            .clk   (clk),
            .reset (reset),
            .load  (load[i]),
            .fin   (fin[i]),
            .oor   (oor_q),
            .cap   (cap),
            .gnt   (gnt[i]),
            .done  (done[i]),
            .err   (err[i]),
            .rdata (rdata[i])
        );
    end

    assign a_gnt   = gnt[0];
    assign b_gnt   = gnt[1];
    assign a_done  = done[0];
    assign b_done  = done[1];
    assign a_err   = err[0];
    assign b_err   = err[1];
    assign a_rdata = rdata[0];
    assign b_rdata = rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single-access vector table plus tie, streaming and reset sequences.

module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, a_done, a_err, b_gnt, b_done, b_err;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] DMEM_address;
    logic [DW-1:0] DMEM_data_in, DMEM_data_out;
    logic          DMEM_mem_write, DMEM_mem_read;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem [32];
    logic          init_done = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(21), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
        .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
        .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
        .DMEM_data_out(DMEM_data_out)
    );

    // memory: mem[i] preloaded to 0x1000_0000 + i
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (DMEM_mem_write && DMEM_address < 32) begin
            mem[DMEM_address[4:0]] <= DMEM_data_in;
        end
    end
    assign DMEM_data_out = (DMEM_address < 32) ? mem[DMEM_address[4:0]] : '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        is_b;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_wr;
        logic        exp_rd;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(logic is_b, logic we, logic [31:0] addr, logic [31:0] wdata,
                                logic exp_wr, logic exp_rd, logic exp_err, logic [31:0] exp_rdata);
        vec_t v;
        v.is_b = is_b; v.we = we; v.addr = addr; v.wdata = wdata;
        v.exp_wr = exp_wr; v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        a_req = !v.is_b; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
        b_req = v.is_b;  b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
        @(posedge clk); @(negedge clk);
        chk($sformatf("v%0d a_gnt", idx), 32'(a_gnt), 32'(!v.is_b));
        chk($sformatf("v%0d b_gnt", idx), 32'(b_gnt), 32'(v.is_b));
        chk($sformatf("v%0d wr", idx), 32'(DMEM_mem_write), 32'(v.exp_wr));
        chk($sformatf("v%0d rd", idx), 32'(DMEM_mem_read), 32'(v.exp_rd));
        chk($sformatf("v%0d addr", idx), DMEM_address, v.addr);
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk($sformatf("v%0d a_done", idx), 32'(a_done), 32'(!v.is_b));
        chk($sformatf("v%0d b_done", idx), 32'(b_done), 32'(v.is_b));
        chk($sformatf("v%0d err", idx), 32'(v.is_b ? b_err : a_err), 32'(v.exp_err));
        chk($sformatf("v%0d other_err", idx), 32'(v.is_b ? a_err : b_err), 32'd0);
        chk($sformatf("v%0d rdata", idx), v.is_b ? b_rdata : a_rdata, v.exp_rdata);
        chk($sformatf("v%0d strobes_done", idx), 32'({DMEM_mem_write, DMEM_mem_read}), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = mk(1'b0, 1'b1, 32'd3,  32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0);
        vt[1] = mk(1'b0, 1'b0, 32'd3,  32'h0,         1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        vt[2] = mk(1'b1, 1'b0, 32'd21, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0);
        vt[3] = mk(1'b1, 1'b1, 32'd7,  32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0);
        vt[4] = mk(1'b1, 1'b0, 32'd7,  32'h0,         1'b0, 1'b1, 1'b0, 32'h1234_5678);
        vt[5] = mk(1'b0, 1'b0, 32'd20, 32'h0,         1'b0, 1'b1, 1'b0, 32'h1000_0014);
        vt[6] = mk(1'b0, 1'b1, 32'd25, 32'h5555_AAAA, 1'b0, 1'b0, 1'b1, 32'h0);
        vt[7] = mk(1'b1, 1'b0, 32'd0,  32'h0,         1'b0, 1'b1, 1'b0, 32'h1000_0000);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        init_done = 1'b1;
        chk("rst gnt",   32'({a_gnt, b_gnt}), 32'd0);
        chk("rst done",  32'({a_done, b_done}), 32'd0);
        chk("rst err",   32'({a_err, b_err}), 32'd0);
        chk("rst a_rdata", a_rdata, 32'd0);
        chk("rst b_rdata", b_rdata, 32'd0);
        chk("rst addr",  DMEM_address, 32'd0);
        chk("rst wdata", DMEM_data_in, 32'd0);
        chk("rst strobes", 32'({DMEM_mem_write, DMEM_mem_read}), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // tie after reset: A, then B, then A again
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd2;
        @(posedge clk); @(negedge clk);
        chk("tie1 a_gnt", 32'(a_gnt), 32'd1);
        chk("tie1 b_gnt", 32'(b_gnt), 32'd0);
        a_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("tie1 a_done", 32'(a_done), 32'd1);
        chk("tie1 a_rdata", a_rdata, 32'h1000_0001);
        chk("tie1 b_done", 32'(b_done), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("tie2 b_gnt", 32'(b_gnt), 32'd1);
        chk("tie2 a_gnt", 32'(a_gnt), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("tie2 b_done", 32'(b_done), 32'd1);
        chk("tie2 b_rdata", b_rdata, 32'h1000_0002);
        a_req = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("tie3 a_gnt", 32'(a_gnt), 32'd1);
        chk("tie3 b_gnt", 32'(b_gnt), 32'd0);
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(posedge clk);

        // A back-to-back reads of 0,1,2
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("b2b%0d a_gnt", k), 32'(a_gnt), 32'd1);
            chk($sformatf("b2b%0d addr", k), DMEM_address, 32'(k));
            if (k < 2) a_addr = 32'(k + 1);
            else       a_req = 1'b0;
            @(posedge clk); @(negedge clk);
            chk($sformatf("b2b%0d gap", k), 32'(a_gnt), 32'd0);
            chk($sformatf("b2b%0d a_done", k), 32'(a_done), 32'd1);
            chk($sformatf("b2b%0d a_rdata", k), a_rdata, 32'h1000_0000 + 32'(k));
        end
        @(posedge clk);

        // B streams for 6 cycles with A idle
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd4;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("bs%0d b_gnt", k), 32'(b_gnt), 32'((k % 2) == 0));
            chk($sformatf("bs%0d b_done", k), 32'(b_done), 32'((k % 2) == 1));
            chk($sformatf("bs%0d a_side", k), 32'({a_gnt, a_done}), 32'd0);
            if (k == 5) b_req = 1'b0;
        end
        @(posedge clk);

        // reset during a B write's ACCESS cycle
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'd5; b_wdata = 32'h0000_CAFE;
        @(posedge clk);
        #2;
        chk("rstacc wr_before", 32'(DMEM_mem_write), 32'd1);
        reset = 1'b0;
        #1;
        chk("rstacc wr_dropped", 32'(DMEM_mem_write), 32'd0);
        chk("rstacc b_gnt", 32'(b_gnt), 32'd0);
        @(negedge clk);
        b_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rstacc b_done", 32'(b_done), 32'd0);
        chk("rstacc outs", 32'({a_gnt, b_gnt, a_done, b_done, a_err, b_err,
                                 DMEM_mem_write, DMEM_mem_read}), 32'd0);
        chk("rstacc addr", DMEM_address, 32'd0);
        chk("rstacc b_rdata", b_rdata, 32'd0);
        chk("rstacc mem5", mem[5], 32'h1000_0005);
        reset = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'd6;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'd8;
        @(posedge clk); @(negedge clk);
        chk("rstacc tie a_gnt", 32'(a_gnt), 32'd1);
        chk("rstacc tie b_gnt", 32'(b_gnt), 32'd0);
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rstacc tie a_rdata", a_rdata, 32'h1000_0006);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 21, SHALL give the number of valid data-memory words (addresses 0..DEPTH-1).
REQ-002 Parameter AW, default 32, SHALL give the address width.
REQ-003 Parameter DW, default 32, SHALL give the data width.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 a_req / b_req  in  1  SHALL be the access request from requester A (CPU MEM stage) or B (loader/debug port).
REQ-007 a_we / b_we  in  1  SHALL select write (1) or read (0).
REQ-008 a_addr / b_addr  in  AW  SHALL be the word address.
REQ-009 a_wdata / b_wdata  in  DW  SHALL be the write data.
REQ-010 a_gnt / b_gnt  out  1  SHALL be a one-cycle registered grant.
REQ-011 a_done / b_done  out  1  SHALL be a one-cycle registered completion pulse.
REQ-012 a_rdata / b_rdata  out  DW  SHALL be the registered read data, valid while the matching done is high.
REQ-013 a_err / b_err  out  1  SHALL pulse with done when the address was out of range.
REQ-014 DMEM_address  out  AW  SHALL drive the memory address.
REQ-015 DMEM_data_in  out  DW  SHALL drive the memory write data.
REQ-016 DMEM_mem_write / DMEM_mem_read  out  1  SHALL be the memory strobes.
REQ-017 DMEM_data_out  in  DW  SHALL be the combinational memory read data.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-019 In IDLE or DONE, if any req is high, the block SHALL select one requester, register its addr/we/wdata onto the DMEM outputs, and move to ACCESS; otherwise it SHALL move to IDLE.
REQ-020 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; with one request high, that requester wins.
REQ-021 In ACCESS, the winner's gnt SHALL be high for exactly that cycle, and exactly one strobe SHALL be asserted: DMEM_mem_write if we=1, DMEM_mem_read if we=0.
REQ-022 Strobes SHALL be suppressed in ACCESS when addr >= DEPTH; err SHALL then pulse in DONE.
REQ-023 At the end of ACCESS, read data SHALL be captured from DMEM_data_out. Captured data SHALL be 0 for writes and for out-of-range accesses.
REQ-024 In DONE, the winner's done SHALL be high for one cycle with rdata valid.
REQ-025 Latency: req sampled at edge N -> gnt in cycle N+1 -> done in cycle N+2. Back-to-back throughput SHALL be one access per 2 cycles.
REQ-026 A requester SHALL hold req/addr/we/wdata stable until it sees gnt and SHALL drop req in the cycle after gnt unless it issues a new request. Any req high in DONE SHALL be treated as a new request.
REQ-027 Outside ACCESS, both strobes SHALL be 0. DMEM_address and DMEM_data_in SHALL hold their last values.
REQ-028 gnt, done and err SHALL never be high for both requesters in the same cycle.

Reset
REQ-029 While reset=0, the state SHALL be IDLE, and all outputs (gnt, done, err, rdata, DMEM_address, DMEM_data_in, strobes) SHALL be 0. The round-robin pointer SHALL be "last served = B", so A wins the first tie.
REQ-030 Reset asserted during ACCESS SHALL drop the strobes immediately (asynchronously). The aborted access SHALL produce no done.
REQ-031 After reset deasserts, arbitration SHALL resume on the first rising edge.

Verification
REQ-032 A writes addr 3 = 0xDEADBEEF, then A reads addr 3 -> one DMEM_mem_write cycle with address 3; read done with a_rdata=0xDEADBEEF, a_err=0.
REQ-033 A and B request simultaneously after reset -> A granted first, B granted at the next arbitration point; repeat the tie -> A is served after B (alternation).
REQ-034 B reads addr 21 (DEPTH=21) -> no strobe asserted; b_done and b_err pulse together; b_rdata=0.
REQ-035 A issues back-to-back reads of addr 0,1,2 -> grants 2 cycles apart; each done carries the matching memory word.
REQ-036 reset pulled low in the ACCESS cycle of a B write to addr 5 -> DMEM_mem_write drops within the same cycle; no b_done; all outputs 0; first post-reset tie goes to A.
REQ-037 B holds req high for 6 cycles with A idle -> B served every 2 cycles; b_gnt and b_done never coincide with a_gnt or a_done.
